// File: rtl/snn_feeder.sv
// Collects an 85-byte frame from the host, streams it to the SNN core for 72 cycles, then holds the core result or a timeout flag until the host takes it.
// snn_in_valid rises the cycle after the last byte; s_ready stays low from frame end until the result handshake.
module snn_feeder #(
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [7:0] s_data,
   output logic       snn_in_valid,
   output logic [7:0] snn_img,
   output logic [7:0] snn_ker,
   output logic [7:0] snn_weight,
   input  logic       snn_out_valid,
   input  logic [9:0] snn_out_data,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [9:0] res_data,
   output logic       res_err
);

   typedef enum logic [1:0] {LOAD, SEND, WAIT, HOLD} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] mem [0:84];
   logic [6:0] load_cnt;
   logic [6:0] send_idx;
   logic [6:0] nxt_idx;
   logic [7:0] timer;

   assign s_ready   = (state == LOAD);
   assign res_valid = (state == HOLD);
   assign nxt_idx   = send_idx + 7'd1;

   // Frame byte map: 0..3 weights, 4..12 kernel, 13..84 image A then B.
   always_ff @(posedge clk) begin
      if (state == LOAD && s_valid)
         mem[load_cnt] <= s_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= LOAD;
         load_cnt     <= 7'd0;
         send_idx     <= 7'd0;
         timer        <= 8'd0;
         snn_in_valid <= 1'b0;
         snn_img      <= 8'd0;
         snn_ker      <= 8'd0;
         snn_weight   <= 8'd0;
         res_data     <= 10'd0;
         res_err      <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (s_valid) begin
                  if (load_cnt == 7'd84) begin
                     // Byte 84 lands this edge; t=0 only needs bytes 0, 4 and 13.
                     state        <= SEND;
                     load_cnt     <= 7'd0;
                     send_idx     <= 7'd0;
                     snn_in_valid <= 1'b1;
                     snn_img      <= mem[13];
                     snn_ker      <= mem[4];
                     snn_weight   <= mem[0];
                  end else begin
                     load_cnt <= load_cnt + 7'd1;
                  end
               end
            end
            SEND: begin
               if (send_idx == 7'd71) begin
                  state        <= WAIT;
                  timer        <= 8'd0;
                  snn_in_valid <= 1'b0;
                  snn_img      <= 8'd0;
                  snn_ker      <= 8'd0;
                  snn_weight   <= 8'd0;
               end else begin
                  send_idx   <= nxt_idx;
                  snn_img    <= mem[7'd13 + nxt_idx];
                  snn_ker    <= (nxt_idx < 7'd9) ? mem[7'd4 + nxt_idx] : 8'd0;
                  snn_weight <= (nxt_idx < 7'd4) ? mem[nxt_idx] : 8'd0;
               end
            end
            WAIT: begin
               // A core result on the final timeout cycle still counts as a result.
               if (snn_out_valid) begin
                  res_data <= snn_out_data;
                  res_err  <= 1'b0;
                  state    <= HOLD;
               end else if (timer == TMO_LAST) begin
                  timer    <= timer + 8'd1;
                  res_data <= 10'd0;
                  res_err  <= 1'b1;
                  state    <= HOLD;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            HOLD: begin
               if (res_ready) begin
                  state    <= LOAD;
                  load_cnt <= 7'd0;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_snn_feeder.sv
// Directed bench for snn_feeder: two instances (default TIMEOUT and TIMEOUT=5) share all inputs.
module tb_snn_feeder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s_valid;
   logic [7:0] s_data;
   logic       snn_out_valid;
   logic [9:0] snn_out_data;
   logic       res_ready;

   logic       a_s_ready, a_in_valid, a_res_valid, a_res_err;
   logic [7:0] a_img, a_ker, a_w;
   logic [9:0] a_res_data;
   logic       b_s_ready, b_in_valid, b_res_valid, b_res_err;
   logic [7:0] b_img, b_ker, b_w;
   logic [9:0] b_res_data;

   int checks = 0;
   int errors = 0;
   logic [7:0] img_seen [72];
   logic [7:0] ker_seen [72];
   logic [7:0] w_seen   [72];

   always #5 clk = ~clk;

   snn_feeder u_a (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
      .snn_in_valid(a_in_valid), .snn_img(a_img), .snn_ker(a_ker), .snn_weight(a_w),
      .snn_out_valid(snn_out_valid), .snn_out_data(snn_out_data),
      .res_valid(a_res_valid), .res_ready(res_ready), .res_data(a_res_data), .res_err(a_res_err)
   );

   snn_feeder #(.TIMEOUT(5)) u_b (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
      .snn_in_valid(b_in_valid), .snn_img(b_img), .snn_ker(b_ker), .snn_weight(b_w),
      .snn_out_valid(snn_out_valid), .snn_out_data(snn_out_data),
      .res_valid(b_res_valid), .res_ready(res_ready), .res_data(b_res_data), .res_err(b_res_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Bytes are base, base+1, ...; returns at the negedge that presents byte 84.
   task automatic load_frame(input logic [7:0] base, input bit gaps);
      int i = 0;
      int cyc = 0;
      while (i < 85 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (gaps && $urandom_range(0, 2) == 0) begin
            s_valid = 1'b0;
         end else begin
            s_valid = 1'b1;
            s_data  = base + 8'(i);
         end
         if (s_valid && a_s_ready) i++;
      end
      chk("load_bytes_accepted", i, 85);
   endtask

   task automatic check_frame(input logic [7:0] base, input int n, input bit keep_valid);
      logic [7:0] e_img, e_ker, e_w;
      for (int t = 0; t < n; t++) begin
         @(negedge clk);
         if (t == 0) begin
            s_valid = keep_valid;
            s_data  = 8'hEE;
         end
         e_img = base + 8'(13 + t);
         e_ker = (t < 9) ? base + 8'(4 + t) : 8'd0;
         e_w   = (t < 4) ? base + 8'(t) : 8'd0;
         img_seen[t] = a_img;
         ker_seen[t] = a_ker;
         w_seen[t]   = a_w;
         chk("send_in_valid", a_in_valid, 1);
         chk("send_img", a_img, e_img);
         chk("send_ker", a_ker, e_ker);
         chk("send_weight", a_w, e_w);
         chk("send_s_ready", a_s_ready, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_data = 8'd0;
      snn_out_valid = 1'b0; snn_out_data = 10'd0; res_ready = 1'b0;
      #12;
      chk("rst_s_ready", a_s_ready, 1);
      chk("rst_in_valid", a_in_valid, 0);
      chk("rst_img", a_img, 0);
      chk("rst_ker", a_ker, 0);
      chk("rst_weight", a_w, 0);
      chk("rst_res_valid", a_res_valid, 0);
      chk("rst_res_data", a_res_data, 0);
      chk("rst_res_err", a_res_err, 0);
      @(negedge clk) rst_n = 1'b1;

      // Frame 1..85, core answers 300 on the 8th WAIT cycle; short-timeout instance times out.
      load_frame(8'd1, 1'b0);
      check_frame(8'd1, 72, 1'b0);
      chk("t0_img", img_seen[0], 14);
      chk("t0_ker", ker_seen[0], 5);
      chk("t0_weight", w_seen[0], 1);
      chk("t3_weight", w_seen[3], 4);
      chk("t4_weight", w_seen[4], 0);
      chk("t8_ker", ker_seen[8], 13);
      chk("t9_ker", ker_seen[9], 0);
      chk("t71_img", img_seen[71], 85);
      for (int w = 1; w <= 8; w++) begin
         @(negedge clk);
         if (w == 1) begin
            res_ready = 1'b1;
            chk("wait_in_valid", a_in_valid, 0);
            chk("wait_img", a_img, 0);
            chk("wait_ker", a_ker, 0);
         end
         chk("wait_res_valid", a_res_valid, 0);
         chk("tmo_res_valid", b_res_valid, (w == 6));
         if (w == 6) begin
            chk("tmo_res_data", b_res_data, 0);
            chk("tmo_res_err", b_res_err, 1);
         end
         if (w == 8) begin
            snn_out_valid = 1'b1;
            snn_out_data  = 10'd300;
         end
      end
      @(negedge clk);
      snn_out_valid = 1'b0;
      chk("hold_res_valid", a_res_valid, 1);
      chk("hold_res_data", a_res_data, 300);
      chk("hold_res_err", a_res_err, 0);
      chk("hold_s_ready", a_s_ready, 0);
      chk("tmo_ignores_out_valid", b_res_valid, 0);
      @(negedge clk);
      chk("after_hs_res_valid", a_res_valid, 0);
      chk("after_hs_s_ready", a_s_ready, 1);
      res_ready = 1'b0;

      // Core result on the last timeout cycle wins over the timeout.
      load_frame(8'd100, 1'b0);
      check_frame(8'd100, 72, 1'b0);
      for (int w = 1; w <= 5; w++) begin
         @(negedge clk);
         chk("race_wait_res_valid", b_res_valid, 0);
         if (w == 5) begin
            snn_out_valid = 1'b1;
            snn_out_data  = 10'd513;
         end
      end
      @(negedge clk);
      snn_out_valid = 1'b0;
      res_ready     = 1'b1;
      chk("race_res_valid", b_res_valid, 1);
      chk("race_res_data", b_res_data, 513);
      chk("race_res_err", b_res_err, 0);
      chk("race_a_res_data", a_res_data, 513);
      @(negedge clk);
      chk("race_done_a", a_res_valid, 0);
      chk("race_done_b", b_res_valid, 0);
      res_ready = 1'b0;

      // Gappy load, s_valid stuck high afterwards, long HOLD with ignored core pulses.
      load_frame(8'd1, 1'b1);
      check_frame(8'd1, 72, 1'b1);
      for (int w = 1; w <= 3; w++) begin
         @(negedge clk);
         chk("gap_wait_s_ready", a_s_ready, 0);
         if (w == 3) begin
            snn_out_valid = 1'b1;
            snn_out_data  = 10'd77;
         end
      end
      for (int h = 1; h <= 20; h++) begin
         @(negedge clk);
         snn_out_valid = (h % 3 == 0);
         snn_out_data  = 10'd999;
         chk("stall_res_valid", a_res_valid, 1);
         chk("stall_res_data", a_res_data, 77);
         chk("stall_res_err", a_res_err, 0);
         chk("stall_s_ready", a_s_ready, 0);
         chk("stall_b_res_data", b_res_data, 77);
      end
      @(negedge clk);
      snn_out_valid = 1'b0;
      s_valid       = 1'b0;
      res_ready     = 1'b1;
      chk("stall_last_res_valid", a_res_valid, 1);
      @(negedge clk);
      chk("stall_done_res_valid", a_res_valid, 0);
      chk("stall_done_s_ready", a_s_ready, 1);
      res_ready = 1'b0;

      // Reset in the middle of SEND, then a partial load discarded by reset.
      load_frame(8'd50, 1'b0);
      check_frame(8'd50, 30, 1'b0);
      @(negedge clk);
      chk("t30_in_valid", a_in_valid, 1);
      chk("t30_img", a_img, 93);
      #2 rst_n = 1'b0;
      #1;
      chk("async_in_valid", a_in_valid, 0);
      chk("async_img", a_img, 0);
      chk("async_s_ready", a_s_ready, 1);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = 8'hAA;
      end
      @(negedge clk);
      s_valid = 1'b0;
      rst_n   = 1'b0;
      #1 chk("partial_rst_s_ready", a_s_ready, 1);
      @(negedge clk) rst_n = 1'b1;
      load_frame(8'd7, 1'b0);
      check_frame(8'd7, 72, 1'b0);
      @(negedge clk);
      chk("fresh_wait_in_valid", a_in_valid, 0);
      snn_out_valid = 1'b1;
      snn_out_data  = 10'd5;
      res_ready     = 1'b1;
      @(negedge clk);
      snn_out_valid = 1'b0;
      chk("fresh_res_valid", a_res_valid, 1);
      chk("fresh_res_data", a_res_data, 5);
      chk("fresh_res_err", a_res_err, 0);
      @(negedge clk);
      chk("fresh_done_res_valid", a_res_valid, 0);
      res_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/snn_feeder.md
SNN_FEEDER -- requirements
Module: snn_feeder

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 64: maximum cycles allowed in WAIT before an error result is raised; legal range 1..255.
REQ-002 SHALL provide port clk  input  1  rising-edge clock.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port s_valid  input  1  host byte valid.
REQ-005 SHALL provide port s_ready  output  1  feeder accepts a host byte.
REQ-006 SHALL provide port s_data  input  8  host byte, unsigned.
REQ-007 SHALL provide port snn_in_valid  output  1  input-valid driven to the SNN core.
REQ-008 SHALL provide port snn_img  output  8  image byte to the core.
REQ-009 SHALL provide port snn_ker  output  8  kernel byte to the core.
REQ-010 SHALL provide port snn_weight  output  8  weight byte to the core.
REQ-011 SHALL provide port snn_out_valid  input  1  result strobe from the core.
REQ-012 SHALL provide port snn_out_data  input  10  result value from the core.
REQ-013 SHALL provide port res_valid  output  1  result available to the host.
REQ-014 SHALL provide port res_ready  input  1  host accepts the result.
REQ-015 SHALL provide port res_data  output  10  captured result.
REQ-016 SHALL provide port res_err  output  1  result is a timeout, not a core output.

Function
REQ-017 SHALL implement the FSM states LOAD, SEND, WAIT and HOLD; LOAD SHALL be the reset state.
REQ-018 In LOAD, s_ready SHALL be 1; a byte SHALL be stored on each cycle with s_valid&&s_ready; all other states SHALL hold s_ready at 0 and ignore s_valid.
REQ-019 The frame SHALL be 85 bytes in this fixed order: weight w00,w01,w10,w11 (4), then kernel k0..k8 (9), then image A row-major (36), then image B row-major (36).
REQ-020 The 7-bit load counter SHALL reset to 0 on entry to LOAD; on acceptance of byte 84 the FSM SHALL move to SEND on the next edge.
REQ-021 In SEND, send index t SHALL run 0..71; snn_in_valid SHALL be 1 for exactly 72 consecutive cycles, starting the cycle after byte 84 is accepted.
REQ-022 At send index t: snn_img SHALL equal image byte t (A for t<36, B thereafter); snn_ker SHALL equal k[t] when t<9, else 0; snn_weight SHALL equal w[t] when t<4, else 0.
REQ-023 All snn_* outputs SHALL be registered; when snn_in_valid is 0, snn_img, snn_ker and snn_weight SHALL be 0.
REQ-024 After t=71 the FSM SHALL enter WAIT with the 8-bit timeout counter cleared to 0.
REQ-025 In WAIT, snn_out_valid=1 SHALL capture snn_out_data into res_data with res_err=0, and the FSM SHALL enter HOLD.
REQ-026 In WAIT, the counter SHALL increment each cycle without snn_out_valid; on reaching TIMEOUT the FSM SHALL enter HOLD with res_data=0 and res_err=1.
REQ-027 snn_out_valid in the same cycle the counter reaches TIMEOUT SHALL win: the data SHALL be captured with res_err=0.
REQ-028 snn_out_valid in LOAD, SEND or HOLD SHALL be ignored.
REQ-029 In HOLD, res_valid SHALL be 1 with res_data and res_err stable; on res_valid&&res_ready the FSM SHALL return to LOAD on the next edge and res_valid SHALL drop.
REQ-030 res_ready=1 already present on the first HOLD cycle SHALL complete the handshake in that cycle, giving one res_valid cycle.
REQ-031 Frame storage SHALL be overwritten by each new load; stale bytes SHALL never be sent, because SEND requires all 85 bytes.
REQ-032 Throughput SHALL be one frame in flight; no byte of frame N+1 SHALL be accepted before result N is handshaken.

Reset
REQ-033 On rst_n low the block SHALL asynchronously force state LOAD, all counters 0, s_ready 1, snn_in_valid 0, snn_img/ker/weight 0, res_valid 0, res_data 0, res_err 0.
REQ-034 Reset during SEND SHALL drop snn_in_valid immediately, without waiting for the clock; a partially loaded frame SHALL be discarded.

Verification
REQ-035 The bench SHALL cover: load 85 bytes with values 1..85 -> snn_in_valid high 72 cycles; at t=0 img=14, ker=5, weight=1; at t=3 weight=4; at t=8 ker=13; at t=9 ker=0; at t=71 img=85.
REQ-036 The bench SHALL cover: core returns out_valid with data 10'd300 eight cycles into WAIT, res_ready held 1 -> exactly one res_valid cycle, res_data=300, res_err=0, s_ready=1 on the next cycle.
REQ-037 The bench SHALL cover: TIMEOUT=5 with no out_valid -> HOLD after 5 WAIT cycles, res_data=0, res_err=1; a second case with out_valid on cycle 5 -> res_err=0.
REQ-038 The bench SHALL cover: s_valid toggled randomly during load, plus s_valid held high during SEND/WAIT/HOLD -> same frame on snn_* as the gap-free load, with no extra bytes consumed.
REQ-039 The bench SHALL cover: rst_n pulsed low at t=30 of SEND -> snn_in_valid 0 asynchronously; a fresh 85-byte load afterwards produces a correct 72-cycle frame.
REQ-040 The bench SHALL cover: res_ready held 0 for 20 cycles in HOLD -> res_valid and res_data stable throughout, s_ready 0, and out_valid pulses ignored.
